c_mutex_split2_2b: RTL and testbench
====================================

// Module: c_mutex_split2_2b
// PURPOSE
//  Receive-side counterpart of the 2-way mutex merge: decodes the merged drive
//  plus its 2-phase channel-state vector back into per-channel drive pulses.
//  Routes each returned channel free back upstream as a freeNext pulse.
//  Synchronous, single-clock model for the clocked integration shell between
//  the merge stage and the per-channel consumers.
// PARAMETERS
//  NUM_CH      2  number of output channels; the 2b variant fixes this at 2
//  DATA_WIDTH  2  width of i_data; must equal NUM_CH (one toggle bit per channel)
//  FIRE_DELAY  2  cycles from an o_drive pulse to the matching o_fire pulse; legal range 1..8
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-high
//  i_drive      in   1           one-cycle pulse: a merged transfer is present
//  i_data       in   DATA_WIDTH  channel toggle vector from the merge; sampled when i_drive=1
//  i_free       in   NUM_CH      one-cycle pulse per channel: the consumer has released it
//  o_drive      out  NUM_CH      one-cycle dispatch pulse to channel i
//  o_fire       out  1           o_drive activity delayed by FIRE_DELAY cycles
//  o_freeNext   out  1           one-cycle pulse upstream: one channel transaction has completed
//  o_busy       out  NUM_CH      channel i holds an outstanding transaction
//  o_err        out  1           sticky protocol-error flag; cleared only by rst
// BEHAVIOUR
//  Reset: shadow register last_data=0; all channels IDLE; free-pending bits=0;
//   fire shift register=0. All outputs are 0 while rst=1 and in the cycle after release.
//   Asserting rst mid-transfer drops everything in flight, including pending frees and fires.
//  Decode: on i_drive, compute diff = i_data ^ last_data.
//   - Exactly one bit i set: the transfer is valid; last_data<=i_data.
//     * Channel i IDLE: o_drive[i]=1 in the next cycle (latency 1); channel i goes BUSY.
//     * Channel i BUSY: no dispatch; o_err<=1; last_data is still updated.
//   - diff==0 or popcount(diff)>1: no dispatch; o_err<=1; last_data is not updated.
//   - When i_drive=0, i_data is ignored.
//  Channel FSM (per channel): IDLE -(valid decode)-> BUSY -(i_free[i])-> IDLE.
//   - i_free[i] while IDLE: ignored, and o_err<=1.
//   - i_free[i] and a valid i_drive to the same channel i in the same cycle:
//     the free is processed first, so the channel ends BUSY with a new o_drive[i] pulse.
//  Free return: a free accepted on channel i sets pend[i].
//   - Each cycle, at most one pend bit is retired, lowest index first.
//     Retiring a bit clears it and pulses o_freeNext in the next cycle.
//   - Two simultaneous frees produce o_freeNext on two consecutive cycles.
//   - A new free on a channel whose pend bit is already set is counted (pend is a
//     2-bit counter per channel, saturating at 3); saturation sets o_err.
//  Fire: o_fire(t+FIRE_DELAY) = |o_drive(t). Implemented as a shift register;
//   back-to-back dispatches yield back-to-back o_fire pulses.
//  o_busy mirrors FSM state (BUSY=1), registered.
// TESTING
//  1 reset: rst=1, then release with i_drive=0 -> every output stays 0;
//    the first drive with i_data=2'b01 -> o_drive=2'b01 at t+1, o_fire at t+3.
//  2 alternation: drives with i_data 01, 11, 10, 00, each followed by the matching
//    i_free -> o_drive sequence 01, 10, 01, 10; o_err stays 0; one o_freeNext per free.
//  3 busy collision: drive with i_data=01, then drive with i_data=00 before i_free[0]
//    -> no second o_drive; o_err=1; last_data=00.
//  4 bad vector: with last_data=00, drive with i_data=11 -> no dispatch; o_err=1;
//    a following drive with i_data=01 still dispatches to channel 0.
//  5 simultaneous frees: both channels BUSY, i_free=2'b11 in one cycle
//    -> o_freeNext pulses on t+1 and t+2; o_busy=00 at t+1.
//  6 reset mid-op: i_drive at t, rst pulsed at t+1 -> no o_fire and no o_freeNext
//    afterwards; o_busy=00.

Source files
------------

// File: rtl/c_mutex_split2_2b_if.sv
// ============================================================================
// c_mutex_split2_2b_if : handshake bundle between the mutex merge and the split
// Rev 1.0
// ============================================================================
`default_nettype none

interface c_mutex_split2_2b_if #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 2
);
   logic                  i_drive;
   logic [DATA_WIDTH-1:0] i_data;
   logic [NUM_CH-1:0]     i_free;
   logic [NUM_CH-1:0]     o_drive;
   logic                  o_fire;
   logic                  o_freeNext;
   logic [NUM_CH-1:0]     o_busy;
   logic                  o_err;

   modport slave (
      input  i_drive, i_data, i_free,
      output o_drive, o_fire, o_freeNext, o_busy, o_err
   );

   modport master (
      output i_drive, i_data, i_free,
      input  o_drive, o_fire, o_freeNext, o_busy, o_err
   );
endinterface

`default_nettype wire

// File: rtl/c_mutex_split2_2b.sv
// ============================================================================
// c_mutex_split2_2b : decodes a merged 2-phase drive into per-channel dispatch
//                     pulses and returns channel frees upstream one per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module c_mutex_split2_2b #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 2,
   parameter int FIRE_DELAY = 2
) (
   input  wire logic           clk,
   input  wire logic           rst,
   c_mutex_split2_2b_if.slave  bus
);

   localparam logic [0:0] c_ST_IDLE  = 1'b0;
   localparam logic [0:0] c_ST_BUSY  = 1'b1;
   localparam logic [1:0] c_PEND_MAX = 2'd3;
   localparam logic [DATA_WIDTH-1:0] c_DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_last_data;
   logic [0:0]            r_state     [NUM_CH];
   logic [0:0]            w_state_nxt [NUM_CH];
   logic [1:0]            r_pend      [NUM_CH];
   logic [1:0]            w_pend_nxt  [NUM_CH];
   logic [1:0]            w_pend_cap  [NUM_CH];
   logic [2:0]            w_pend_sum  [NUM_CH];
   logic [NUM_CH-1:0]     r_drive;
   logic [FIRE_DELAY-1:0] r_fire_sr;
   logic                  r_free_next;
   logic                  r_err;

   logic [DATA_WIDTH-1:0] w_diff;
   logic                  w_onehot;
   logic                  w_drv_valid;
   logic                  w_drv_bad;
   logic                  w_collide;
   logic                  w_any_retire;
   logic                  w_err_set;
   logic [NUM_CH-1:0]     w_free_acc;
   logic [NUM_CH-1:0]     w_free_idle;
   logic [NUM_CH-1:0]     w_dispatch;
   logic [NUM_CH-1:0]     w_sat;
   logic [NUM_CH-1:0]     w_busy;

   // A legal transfer toggles exactly one channel bit relative to the shadow copy.
   assign w_diff      = bus.i_data ^ r_last_data;
   assign w_onehot    = (w_diff != '0) && ((w_diff & (w_diff - c_DATA_ONE)) == '0);
   assign w_drv_valid = bus.i_drive && w_onehot;
   assign w_drv_bad   = bus.i_drive && !w_onehot;
   assign w_collide   = w_drv_valid && (w_dispatch == '0);
   assign w_err_set   = w_drv_bad || w_collide || (|w_free_idle) || (|w_sat);

   // ---------------------------------------------------------------- FSM: state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i] <= c_ST_IDLE;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   // ----------------------------------------------------------- FSM: next state
   // The free is applied before the dispatch so a same-cycle free+drive re-arms.
   always_comb begin
      w_free_acc  = '0;
      w_free_idle = '0;
      w_dispatch  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_free_acc[i]  = bus.i_free[i] && (r_state[i] == c_ST_BUSY);
         w_free_idle[i] = bus.i_free[i] && (r_state[i] == c_ST_IDLE);
         w_dispatch[i]  = w_drv_valid && w_diff[i] &&
                          ((r_state[i] == c_ST_IDLE) || w_free_acc[i]);
         if (w_free_acc[i]) begin
            w_state_nxt[i] = c_ST_IDLE;
         end
         if (w_dispatch[i]) begin
            w_state_nxt[i] = c_ST_BUSY;
         end
      end
   end

   // -------------------------------------------------------------- FSM: outputs
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_busy[i] = (r_state[i] == c_ST_BUSY);
      end
   end

   // Pending-free counters: add this cycle's frees, then retire the lowest index.
   always_comb begin
      w_sat        = '0;
      w_any_retire = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pend_sum[i] = {1'b0, r_pend[i]} + {2'b00, w_free_acc[i]};
         w_sat[i]      = w_pend_sum[i][2];
         w_pend_cap[i] = w_sat[i] ? c_PEND_MAX : w_pend_sum[i][1:0];
         w_pend_nxt[i] = w_pend_cap[i];
         if (!w_any_retire && (w_pend_cap[i] != 2'd0)) begin
            w_any_retire  = 1'b1;
            w_pend_nxt[i] = w_pend_cap[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_data <= '0;
         r_drive     <= '0;
         r_free_next <= 1'b0;
         r_err       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_pend[i] <= 2'd0;
         end
      end else begin
         if (w_drv_valid) begin
            r_last_data <= bus.i_data;
         end
         r_drive     <= w_dispatch;
         r_free_next <= w_any_retire;
         r_err       <= r_err | w_err_set;
         for (int i = 0; i < NUM_CH; i++) begin
            r_pend[i] <= w_pend_nxt[i];
         end
      end
   end

   generate
      if (FIRE_DELAY == 1) begin : g_fire_single
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_fire_sr <= '0;
            end else begin
               r_fire_sr <= |r_drive;
            end
         end
      end else begin : g_fire_chain
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_fire_sr <= '0;
            end else begin
               r_fire_sr <= {r_fire_sr[FIRE_DELAY-2:0], |r_drive};
            end
         end
      end
   endgenerate

   assign bus.o_drive    = r_drive;
   assign bus.o_fire     = r_fire_sr[FIRE_DELAY-1];
   assign bus.o_freeNext = r_free_next;
   assign bus.o_busy     = w_busy;
   assign bus.o_err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_c_mutex_split2_2b.sv
// ============================================================================
// tb_c_mutex_split2_2b : directed scenarios plus randomized traffic against a
//                        behavioural model of the 2-way split
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_c_mutex_split2_2b;

   localparam int NUM_CH = 2;
   localparam int DW     = 2;
   localparam int FD     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   c_mutex_split2_2b_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

   c_mutex_split2_2b #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIRE_DELAY(FD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Model state: what a channel-level observer would track.
   bit [1:0] m_last;
   bit       m_busy [NUM_CH];
   int       m_pend [NUM_CH];
   bit       m_err;
   bit [1:0] m_drive;
   bit       m_fn;
   bit       m_fire;
   bit       fireq [$];

   function void model_reset();
      m_last  = 2'b00;
      m_err   = 1'b0;
      m_drive = 2'b00;
      m_fn    = 1'b0;
      m_fire  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_busy[c] = 1'b0;
         m_pend[c] = 0;
      end
      fireq = {};
      for (int k = 0; k < FD; k++) fireq.push_back(1'b0);
   endfunction

   function void model_step(bit d, bit [1:0] dat, bit [1:0] fr);
      bit [1:0] diff;
      int       ch;
      m_drive = 2'b00;
      m_fn    = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (fr[c]) begin
            if (m_busy[c]) begin
               m_busy[c] = 1'b0;
               m_pend[c] = m_pend[c] + 1;
               if (m_pend[c] > 3) begin
                  m_pend[c] = 3;
                  m_err     = 1'b1;
               end
            end else begin
               m_err = 1'b1;
            end
         end
      end
      if (d) begin
         diff = dat ^ m_last;
         if (diff == 2'b01 || diff == 2'b10) begin
            m_last = dat;
            ch = (diff == 2'b01) ? 0 : 1;
            if (!m_busy[ch]) begin
               m_busy[ch]  = 1'b1;
               m_drive[ch] = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_pend[c] > 0) begin
            m_pend[c] = m_pend[c] - 1;
            m_fn      = 1'b1;
            break;
         end
      end
      fireq.push_back(m_drive != 2'b00);
      m_fire = fireq.pop_front();
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("o_drive",    {6'b0, bus.o_drive},   {6'b0, m_drive});
      chk("o_busy",     {6'b0, bus.o_busy},    {6'b0, m_busy[1], m_busy[0]});
      chk("o_freeNext", {7'b0, bus.o_freeNext}, {7'b0, m_fn});
      chk("o_fire",     {7'b0, bus.o_fire},    {7'b0, m_fire});
      chk("o_err",      {7'b0, bus.o_err},     {7'b0, m_err});
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {bus.o_drive, bus.o_busy, bus.o_fire, bus.o_freeNext, bus.o_err}, 8'h00);
   endtask

   task automatic cycle(input bit d, input bit [1:0] dat, input bit [1:0] fr);
      @(negedge clk);
      bus.i_drive = d;
      bus.i_data  = dat;
      bus.i_free  = fr;
      @(posedge clk);
      #1;
      model_step(d, dat, fr);
      chk_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      bus.i_drive = 1'b0;
      bus.i_data  = 2'b00;
      bus.i_free  = 2'b00;
      #1;
      chk_all_zero("rst_async");
      @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog at %0t: got timeout expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit [1:0] seq_data [4];
      bit [1:0] seq_free [4];
      bit [1:0] seq_drv  [4];
      bit       d;
      bit [1:0] dat;
      bit [1:0] fr;

      bus.i_drive = 1'b0;
      bus.i_data  = 2'b00;
      bus.i_free  = 2'b00;
      model_reset();

      // 1: reset and first-dispatch latency
      do_reset();
      cycle(1'b0, 2'b00, 2'b00);
      chk_all_zero("t1_idle_after_release");
      cycle(1'b1, 2'b01, 2'b00);
      chk("t1_drive", {6'b0, bus.o_drive}, 8'h01);
      chk("t1_fire_early", {7'b0, bus.o_fire}, 8'h00);
      cycle(1'b0, 2'b00, 2'b00);
      chk("t1_fire_t2", {7'b0, bus.o_fire}, 8'h00);
      cycle(1'b0, 2'b00, 2'b00);
      chk("t1_fire_t3", {7'b0, bus.o_fire}, 8'h01);

      // 2: alternation
      do_reset();
      seq_data = '{2'b01, 2'b11, 2'b10, 2'b00};
      seq_free = '{2'b01, 2'b10, 2'b01, 2'b10};
      seq_drv  = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, seq_data[k], 2'b00);
         chk("t2_drive", {6'b0, bus.o_drive}, {6'b0, seq_drv[k]});
         cycle(1'b0, 2'b00, seq_free[k]);
         chk("t2_freeNext", {7'b0, bus.o_freeNext}, 8'h01);
      end
      cycle(1'b0, 2'b00, 2'b00);
      chk("t2_err", {7'b0, bus.o_err}, 8'h00);
      chk("t2_busy", {6'b0, bus.o_busy}, 8'h00);

      // 3: collision on a busy channel still updates the shadow copy
      do_reset();
      cycle(1'b1, 2'b01, 2'b00);
      cycle(1'b1, 2'b00, 2'b00);
      chk("t3_no_drive", {6'b0, bus.o_drive}, 8'h00);
      chk("t3_err", {7'b0, bus.o_err}, 8'h01);
      cycle(1'b0, 2'b00, 2'b01);
      cycle(1'b1, 2'b01, 2'b00);
      chk("t3_redispatch", {6'b0, bus.o_drive}, 8'h01);

      // 4: two-bit toggle is rejected without moving the shadow copy
      do_reset();
      cycle(1'b1, 2'b11, 2'b00);
      chk("t4_no_drive", {6'b0, bus.o_drive}, 8'h00);
      chk("t4_err", {7'b0, bus.o_err}, 8'h01);
      cycle(1'b1, 2'b01, 2'b00);
      chk("t4_drive", {6'b0, bus.o_drive}, 8'h01);

      // 5: simultaneous frees return on consecutive cycles
      do_reset();
      cycle(1'b1, 2'b01, 2'b00);
      cycle(1'b1, 2'b11, 2'b00);
      chk("t5_busy_both", {6'b0, bus.o_busy}, 8'h03);
      cycle(1'b0, 2'b00, 2'b11);
      chk("t5_busy_clear", {6'b0, bus.o_busy}, 8'h00);
      chk("t5_fn1", {7'b0, bus.o_freeNext}, 8'h01);
      cycle(1'b0, 2'b00, 2'b00);
      chk("t5_fn2", {7'b0, bus.o_freeNext}, 8'h01);
      cycle(1'b0, 2'b00, 2'b00);
      chk("t5_fn3", {7'b0, bus.o_freeNext}, 8'h00);

      // 6: reset in the middle of a transfer drops everything in flight
      do_reset();
      cycle(1'b1, 2'b01, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("t6_async_clear");
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 2'b00, 2'b00);
         chk_all_zero("t6_quiet");
      end

      // Randomized traffic, re-reset periodically so the sticky error stays informative
      for (int blk = 0; blk < 8; blk++) begin
         do_reset();
         for (int k = 0; k < 250; k++) begin
            d = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 19) == 0) dat = 2'($urandom_range(0, 3));
            else                            dat = m_last ^ (2'b01 << $urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) begin
               if (m_busy[c]) fr[c] = ($urandom_range(0, 3) == 0);
               else           fr[c] = ($urandom_range(0, 39) == 0);
            end
            cycle(d, dat, fr);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
